// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Purpose : shared constants and types for the multicycle MIPS sequencer.
//           Holds the state encoding, the supported opcodes, the datapath
//           select encodings and the packed control word passed from the
//           output decoder to the top level.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // Sequencer states; the numeric codes are visible on state_o for debug.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC    = 4'd7,
        ST_ALUWB   = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_IMMEXEC = 4'd10,
        ST_IMMWB   = 4'd11,
        ST_JUMP    = 4'd12
    } state_e;

    // Supported opcodes (Instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation requested from the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // PC source mux.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand mux.
    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Immediate extension mode.
    localparam logic [1:0] SEXT_SIGN = 2'b00;
    localparam logic [1:0] SEXT_ZERO = 2'b01;

    // Width of the memory stall counter.
    localparam int WAIT_CNT_W = 8;

    // All datapath selects and enables produced for one cycle.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] sig_ext;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_word_t;

    // State entered after DECODE for a given opcode; FETCH means unsupported.
    function automatic state_e decode_target(input logic [5:0] op);
        state_e s;
        case (op)
            OP_LW, OP_SW:    s = ST_MEMADR;
            OP_RTYPE:        s = ST_EXEC;
            OP_BEQ:          s = ST_BRANCH;
            OP_ADDI, OP_ORI: s = ST_IMMEXEC;
            OP_J:            s = ST_JUMP;
            default:         s = ST_FETCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// ---------------------------------------------------------------------------
// mc_out_decode
// Purpose : combinational control-word decoder. Maps the current sequencer
//           state (plus opcode for the immediate ops and mem_ready for the
//           fetch-phase IR/PC loads) onto every datapath select and enable.
// Ports   : i_state     current sequencer state
//           i_opcode    registered instruction opcode
//           i_mem_ready memory completes the current access this cycle
//           o_ctrl      control word for this cycle
// ---------------------------------------------------------------------------
module mc_out_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_e      i_state,
    input  logic [5:0]  i_opcode,
    input  logic        i_mem_ready,
    output ctrl_word_t  o_ctrl
);

    // Per-state control word; anything not set for a state stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_src    = PCSRC_ALU;
                // IR and PC+4 are loaded only on the cycle the fetch lands.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.mem_we  = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_RD2;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_RD2;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            ST_IMMEXEC, ST_IMMWB: begin
                // ALU op and extension are held into writeback so the ALU
                // result stays stable while the register file captures it.
                if (i_state == ST_IMMEXEC) begin
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.alu_src_b = SRCB_IMM;
                end else begin
                    o_ctrl.reg_write = 1'b1;
                end
                if (i_opcode == OP_ORI) begin
                    o_ctrl.alu_op  = ALUOP_OR;
                    o_ctrl.sig_ext = SEXT_ZERO;
                end else begin
                    o_ctrl.alu_op  = ALUOP_ADD;
                    o_ctrl.sig_ext = SEXT_SIGN;
                end
            end
            ST_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Purpose : sequencing FSM for the multicycle MIPS datapath. Steps through
//           fetch / decode / address / execute / writeback phases, stalls on
//           the memory ready handshake and aborts an access that stalls too
//           long.
// Ports   : clk, rstn          clock (rising edge), async active-low reset
//           opcode             Instr[31:26] from the instruction register
//           mem_ready          memory completes current access this cycle
//           mem_req, mem_we,
//           iord               memory request, write strobe, address select
//           ir_write, pc_write,
//           branch, pc_src     IR / PC load controls
//           alu_src_a/b, alu_op,
//           sig_ext            ALU operand / operation selects
//           reg_dst, mem_to_reg,
//           reg_write          register file writeback controls
//           illegal_op         one-cycle pulse after decoding an unsupported op
//           mem_timeout        sticky: a memory access was aborted
//           state_o            current state code, debug
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
)(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] sig_ext,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_MAX);

    state_e                r_state;
    state_e                w_next_state;
    logic [WAIT_CNT_W-1:0] r_wait;
    logic                  r_illegal_op;
    logic                  r_mem_timeout;
    logic                  w_stall;
    logic                  w_timeout;
    logic                  w_illegal;
    ctrl_word_t            w_ctrl;

    mc_out_decode u_out_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // WAIT_LIMIT stall cycles are tolerated; the next cycle that is still
    // not ready aborts the access. A ready on that cycle still completes.
    assign w_stall   = w_ctrl.mem_req & ~mem_ready;
    assign w_timeout = w_stall & (r_wait == WAIT_LIMIT);

    // Next-state selection; DECODE routing comes from the opcode table.
    always_comb begin
        w_next_state = ST_FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            ST_IDLE:   w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                w_next_state = decode_target(opcode);
                w_illegal    = (w_next_state == ST_FETCH);
            end
            ST_MEMADR: begin
                if (opcode == OP_LW) begin
                    w_next_state = ST_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next_state = ST_MEMWR;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEMRD: begin
                if (mem_ready) begin
                    w_next_state = ST_MEMWB;
                end else if (w_timeout) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                if (mem_ready || w_timeout) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_MEMWR;
                end
            end
            ST_EXEC:    w_next_state = ST_ALUWB;
            ST_IMMEXEC: w_next_state = ST_IMMWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_IMMWB, ST_JUMP:
                        w_next_state = ST_FETCH;
            default:    w_next_state = ST_FETCH;
        endcase
    end

    // State register, stall counter and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_wait        <= '0;
            r_illegal_op  <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_illegal_op <= w_illegal;
            if (w_timeout) begin
                r_mem_timeout <= 1'b1;
            end else begin
                r_mem_timeout <= r_mem_timeout;
            end
            // A timeout in FETCH keeps the state, so clear explicitly.
            if (w_timeout || (w_next_state != r_state)) begin
                r_wait <= '0;
            end else if (w_stall) begin
                r_wait <= r_wait + WAIT_CNT_W'(1);
            end else begin
                r_wait <= r_wait;
            end
        end
    end

    assign mem_req     = w_ctrl.mem_req;
    assign mem_we      = w_ctrl.mem_we;
    assign iord        = w_ctrl.iord;
    assign ir_write    = w_ctrl.ir_write;
    assign pc_write    = w_ctrl.pc_write;
    assign branch      = w_ctrl.branch;
    assign pc_src      = w_ctrl.pc_src;
    assign alu_src_a   = w_ctrl.alu_src_a;
    assign alu_src_b   = w_ctrl.alu_src_b;
    assign alu_op      = w_ctrl.alu_op;
    assign sig_ext     = w_ctrl.sig_ext;
    assign reg_dst     = w_ctrl.reg_dst;
    assign mem_to_reg  = w_ctrl.mem_to_reg;
    assign reg_write   = w_ctrl.reg_write;
    assign illegal_op  = r_illegal_op;
    assign mem_timeout = r_mem_timeout;
    assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Purpose : self-checking bench for multicycle_ctrl (WAIT_MAX = 4). A
//           phase-plan model predicts every output on each falling edge;
//           directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int WM = 4;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] sig_ext;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } cw_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_we, iord, ir_write, pc_write, branch;
    logic [1:0] pc_src, alu_src_b, alu_op, sig_ext;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write;
    logic       illegal_op, mem_timeout;
    logic [3:0] state_o;

    multicycle_ctrl #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .branch(branch), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .sig_ext(sig_ext), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase numbers follow the published state codes. After decode the model
    // loads the list of phases the instruction needs and walks it; phases
    // that touch memory (fetch 1, read 4, write 6) wait for mem_ready.
    int  m_cur = 0;
    int  m_stall = 0;
    bit  m_illegal = 1'b0;
    bit  m_timeout = 1'b0;
    int  m_plan[$];

    function automatic cw_t model_word(input int st, input logic [5:0] op, input logic rdy);
        cw_t w;
        w = '0;
        case (st)
            1:  begin w.mem_req = 1'b1; w.alu_src_b = 2'b01; w.ir_write = rdy; w.pc_write = rdy; end
            2:  w.alu_src_b = 2'b11;
            3:  begin w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; end
            4:  begin w.mem_req = 1'b1; w.iord = 1'b1; end
            5:  begin w.reg_write = 1'b1; w.mem_to_reg = 1'b1; end
            6:  begin w.mem_req = 1'b1; w.mem_we = 1'b1; w.iord = 1'b1; end
            7:  begin w.alu_src_a = 1'b1; w.alu_op = 2'b10; end
            8:  begin w.reg_write = 1'b1; w.reg_dst = 1'b1; end
            9:  begin w.alu_src_a = 1'b1; w.alu_op = 2'b01; w.pc_src = 2'b01; w.branch = 1'b1; end
            10: begin
                    w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
                    if (op == T_ORI) begin w.alu_op = 2'b11; w.sig_ext = 2'b01; end
                end
            11: begin
                    w.reg_write = 1'b1;
                    if (op == T_ORI) begin w.alu_op = 2'b11; w.sig_ext = 2'b01; end
                end
            12: begin w.pc_write = 1'b1; w.pc_src = 2'b10; end
            default: w = '0;
        endcase
        return w;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic [23:0] exp_v;
        logic [23:0] act_v;
        bit          ill_n;
        act_v = {state_o, mem_req, mem_we, iord, ir_write, pc_write, branch, pc_src,
                 alu_src_a, alu_src_b, alu_op, sig_ext, reg_dst, mem_to_reg, reg_write,
                 illegal_op, mem_timeout};
        if (!rstn) begin
            exp_v = '0;
            m_cur = 0; m_stall = 0; m_illegal = 1'b0; m_timeout = 1'b0;
            m_plan.delete();
        end else begin
            exp_v = {4'(m_cur), model_word(m_cur, opcode, mem_ready), m_illegal, m_timeout};
        end
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL model t=%0t: dut=%h model=%h", $time, act_v, exp_v);
        end
        if (rstn) begin
            ill_n = 1'b0;
            if (m_cur == 0) begin
                m_cur = 1;
            end else if ((m_cur == 1 || m_cur == 4 || m_cur == 6) && !mem_ready) begin
                if (m_stall == WM) begin
                    m_timeout = 1'b1;
                    m_plan.delete();
                    m_cur = 1;
                    m_stall = 0;
                end else begin
                    m_stall++;
                end
            end else begin
                m_stall = 0;
                if (m_cur == 1) begin
                    m_cur = 2;
                end else begin
                    if (m_cur == 2) begin
                        case (opcode)
                            T_LW:           m_plan = '{3, 4, 5};
                            T_SW:           m_plan = '{3, 6};
                            T_RTYPE:        m_plan = '{7, 8};
                            T_BEQ:          m_plan = '{9};
                            T_ADDI, T_ORI:  m_plan = '{10, 11};
                            T_J:            m_plan = '{12};
                            default:        ill_n = 1'b1;
                        endcase
                    end
                    m_cur = (m_plan.size() > 0) ? m_plan.pop_front() : 1;
                end
            end
            m_illegal = ill_n;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string nm, input int s);
        @(negedge clk);
        chk(nm, int'(state_o), s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lw_seq[5] = '{1, 2, 3, 4, 5};

        // Reset state
        rstn = 1'b0; opcode = T_LW; mem_ready = 1'b1;
        #2;
        chk("rst_state", int'(state_o), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_ir_write", int'(ir_write), 0);
        chk("rst_timeout", int'(mem_timeout), 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        st("idle", 0); adv();

        // lw with memory always ready
        for (int i = 0; i < 5; i++) begin
            st("lw_state", lw_seq[i]);
            chk("lw_reg_write", int'(reg_write), int'(i == 4));
            if (i == 4) chk("lw_mem_to_reg", int'(mem_to_reg), 1);
            adv();
        end

        // sw with three not-ready cycles in MEMWR
        opcode = T_SW;
        st("sw_fetch", 1); adv();
        st("sw_decode", 2); adv();
        st("sw_memadr", 3); adv();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            st("sw_memwr", 6);
            chk("sw_mem_we", int'(mem_we), 1);
            adv();
        end

        // Unsupported opcode
        opcode = 6'h3F;
        st("sw_back_fetch", 1);
        chk("sw_no_timeout", int'(mem_timeout), 0);
        adv();
        st("ill_decode", 2);
        chk("ill_not_yet", int'(illegal_op), 0);
        adv();
        mem_ready = 1'b0;
        st("ill_fetch", 1);
        chk("ill_pulse", int'(illegal_op), 1);
        chk("ill_no_pc_write", int'(pc_write), 0);
        chk("ill_no_reg_write", int'(reg_write), 0);
        adv();
        opcode = T_LW; mem_ready = 1'b1;
        st("ill_fetch2", 1);
        chk("ill_pulse_gone", int'(illegal_op), 0);
        adv();

        // lw with memory never ready -> timeout after WM stall cycles
        st("to_decode", 2); adv();
        st("to_memadr", 3); adv();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            st("to_memrd", 4);
            chk("to_flag_low", int'(mem_timeout), 0);
            adv();
        end
        st("to_abort_fetch", 1);
        chk("to_flag_set", int'(mem_timeout), 1);
        chk("to_no_reg_write", int'(reg_write), 0);
        adv();
        mem_ready = 1'b1;
        st("to_fetch2", 1); adv();
        st("lim_decode", 2); adv();
        st("lim_memadr", 3); adv();

        // Ready arrives exactly at the limit: access completes
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) mem_ready = 1'b1;
            st("lim_memrd", 4);
            adv();
        end
        st("lim_memwb", 5);
        chk("to_sticky", int'(mem_timeout), 1);
        adv();

        // Timeout while fetching restarts FETCH
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            st("fetch_stall", 1);
            adv();
        end

        // ori then addi
        opcode = T_ORI; mem_ready = 1'b1;
        st("ori_fetch", 1); adv();
        st("ori_decode", 2); adv();
        st("ori_exec", 10);
        chk("ori_alu_op", int'(alu_op), 3);
        chk("ori_sig_ext", int'(sig_ext), 1);
        adv();
        st("ori_wb", 11);
        chk("ori_reg_write", int'(reg_write), 1);
        chk("ori_reg_dst", int'(reg_dst), 0);
        chk("ori_wb_alu_op", int'(alu_op), 3);
        adv();
        opcode = T_ADDI;
        st("addi_fetch", 1); adv();
        st("addi_decode", 2); adv();
        st("addi_exec", 10);
        chk("addi_alu_op", int'(alu_op), 0);
        chk("addi_sig_ext", int'(sig_ext), 0);
        adv();
        st("addi_wb", 11);
        chk("addi_reg_write", int'(reg_write), 1);
        chk("addi_reg_dst", int'(reg_dst), 0);
        adv();

        // beq, j, R-type
        opcode = T_BEQ;
        st("beq_fetch", 1); adv();
        st("beq_decode", 2); adv();
        st("beq_branch", 9);
        chk("beq_branch_sig", int'(branch), 1);
        chk("beq_pc_src", int'(pc_src), 1);
        adv();
        opcode = T_J;
        st("j_fetch", 1); adv();
        st("j_decode", 2); adv();
        st("j_jump", 12);
        chk("j_pc_write", int'(pc_write), 1);
        chk("j_pc_src", int'(pc_src), 2);
        adv();
        opcode = T_RTYPE;
        st("r_fetch", 1); adv();
        st("r_decode", 2); adv();
        st("r_exec", 7);
        chk("r_alu_op", int'(alu_op), 2);
        adv();
        st("r_wb", 8);
        chk("r_reg_dst", int'(reg_dst), 1);
        adv();

        // Async reset in the middle of a store
        opcode = T_SW;
        st("rs_fetch", 1); adv();
        st("rs_decode", 2); adv();
        st("rs_memadr", 3); adv();
        mem_ready = 1'b0;
        st("rs_memwr", 6); adv();
        #2;
        rstn = 1'b0;
        #1;
        chk("rs_state", int'(state_o), 0);
        chk("rs_mem_we", int'(mem_we), 0);
        chk("rs_mem_req", int'(mem_req), 0);
        chk("rs_timeout_clr", int'(mem_timeout), 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1; mem_ready = 1'b1;
        st("rs_idle", 0); adv();
        st("rs_fetch_again", 1);
        chk("rs_fetch_req", int'(mem_req), 1);
        adv();
        adv();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
